// File: rtl/alu_sequencer.sv
// Instruction FIFO feeding an external ALU through an issue/capture/hold sequencer.
// Optional macro ALU_SEQ_ILLEGAL_TRAP_EN turns illegal opcodes into error results instead of silent drops.
`timescale 1ns/1ps

module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       IN_OPCODE,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             ALU_EN,
  output logic             ALU_OE,
  output logic [3:0]       ALU_OPCODE,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             ALU_CF,
  input  logic             ALU_OF,
  input  logic             ALU_SF,
  input  logic             ALU_ZF,
  output logic [WIDTH-1:0] RES_DATA,
  output logic             RES_CF,
  output logic             RES_OF,
  output logic             RES_SF,
  output logic             RES_ZF,
  output logic             RES_ERR,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [1:0]       DBG_STATE
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a producer keeps valid and its payload stable until that edge.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [3:0] op);
    return (op >= 4'd2) && (op <= 4'd7);
  endfunction

  function automatic logic is_logic_op(input logic [3:0] op);
    return (op >= 4'd4) && (op <= 4'd7);
  endfunction

  logic [3:0]       op_mem [DEPTH];
  logic [WIDTH-1:0] a_mem  [DEPTH];
  logic [WIDTH-1:0] b_mem  [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic             alu_en_q, alu_en_d, alu_oe_q, alu_oe_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_cf_q, res_cf_d, res_of_q, res_of_d;
  logic             res_sf_q, res_sf_d, res_zf_q, res_zf_d;
  logic             res_valid_q, res_valid_d;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic             res_err_q, res_err_d;
`endif

  logic             push, pop, empty, head_legal;
  logic [3:0]       head_op;
  logic [WIDTH-1:0] head_a, head_b;

  assign IN_READY   = (count_q < CW'(DEPTH));
  assign push       = IN_VALID && IN_READY;
  assign empty      = (count_q == '0);
  assign head_op    = op_mem[rd_ptr_q];
  assign head_a     = a_mem[rd_ptr_q];
  assign head_b     = b_mem[rd_ptr_q];
  assign head_legal = is_legal(head_op);

  always_ff @(posedge CLK) begin
    if (push) begin
      op_mem[wr_ptr_q] <= IN_OPCODE;
      a_mem[wr_ptr_q]  <= IN_A;
      b_mem[wr_ptr_q]  <= IN_B;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    alu_en_d    = 1'b0;
    alu_oe_d    = 1'b0;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_data_d  = res_data_q;
    res_cf_d    = res_cf_q;
    res_of_d    = res_of_q;
    res_sf_d    = res_sf_q;
    res_zf_d    = res_zf_q;
    res_valid_d = res_valid_q;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    res_err_d   = res_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_legal) begin
            state_d  = ISSUE;
            alu_en_d = 1'b1;
            alu_op_d = head_op;
            alu_a_d  = head_a;
            alu_b_d  = head_b;
          end else begin
            pop = 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            res_data_d  = '0;
            res_cf_d    = 1'b0;
            res_of_d    = 1'b0;
            res_sf_d    = 1'b0;
            res_zf_d    = 1'b0;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
            state_d     = HOLD;
`endif
          end
        end
      end
      ISSUE: begin
        pop      = 1'b1;
        alu_oe_d = 1'b1;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        // Carry/overflow are meaningless for bitwise ops, so they are never passed through.
        res_data_d  = ALU_OUT;
        res_cf_d    = is_logic_op(alu_op_q) ? 1'b0 : ALU_CF;
        res_of_d    = is_logic_op(alu_op_q) ? 1'b0 : ALU_OF;
        res_sf_d    = ALU_SF;
        res_zf_d    = ALU_ZF;
        res_valid_d = 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        res_err_d   = 1'b0;
`endif
        state_d     = HOLD;
      end
      HOLD: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          if (!empty && head_legal) begin
            state_d  = ISSUE;
            alu_en_d = 1'b1;
            alu_op_d = head_op;
            alu_a_d  = head_a;
            alu_b_d  = head_b;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_en_q    <= 1'b0;
      alu_oe_q    <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_data_q  <= '0;
      res_cf_q    <= 1'b0;
      res_of_q    <= 1'b0;
      res_sf_q    <= 1'b0;
      res_zf_q    <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_en_q    <= alu_en_d;
      alu_oe_q    <= alu_oe_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_data_q  <= res_data_d;
      res_cf_q    <= res_cf_d;
      res_of_q    <= res_of_d;
      res_sf_q    <= res_sf_d;
      res_zf_q    <= res_zf_d;
      res_valid_q <= res_valid_d;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      res_err_q   <= res_err_d;
`endif
    end
  end

  assign ALU_EN     = alu_en_q;
  assign ALU_OE     = alu_oe_q;
  assign ALU_OPCODE = alu_op_q;
  assign ALU_A      = alu_a_q;
  assign ALU_B      = alu_b_q;
  assign RES_DATA   = res_data_q;
  assign RES_CF     = res_cf_q;
  assign RES_OF     = res_of_q;
  assign RES_SF     = res_sf_q;
  assign RES_ZF     = res_zf_q;
  assign RES_VALID  = res_valid_q;
  assign DBG_STATE  = state_q;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign RES_ERR    = res_err_q;
`else
  assign RES_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural downstream ALU.
// Expected results are hand-computed; define ALU_SEQ_ILLEGAL_TRAP_EN to cover the trap build.
`timescale 1ns/1ps

module tb_alu_sequencer;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [3:0]   IN_OPCODE;
  logic [W-1:0] IN_A, IN_B;
  logic         IN_VALID, IN_READY;
  logic         ALU_EN, ALU_OE;
  logic [3:0]   ALU_OPCODE;
  logic [W-1:0] ALU_A, ALU_B, ALU_OUT;
  logic         ALU_CF, ALU_OF, ALU_SF, ALU_ZF;
  logic [W-1:0] RES_DATA;
  logic         RES_CF, RES_OF, RES_SF, RES_ZF, RES_ERR;
  logic         RES_VALID, RES_READY;
  logic [1:0]   DBG_STATE;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  logic [12:0] exp_q[$];

  always #5 CLK = ~CLK;

  alu_sequencer #(.WIDTH(W), .DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_OPCODE(IN_OPCODE), .IN_A(IN_A), .IN_B(IN_B),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_EN(ALU_EN), .ALU_OE(ALU_OE), .ALU_OPCODE(ALU_OPCODE),
    .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_OUT(ALU_OUT), .ALU_CF(ALU_CF), .ALU_OF(ALU_OF), .ALU_SF(ALU_SF), .ALU_ZF(ALU_ZF),
    .RES_DATA(RES_DATA), .RES_CF(RES_CF), .RES_OF(RES_OF), .RES_SF(RES_SF),
    .RES_ZF(RES_ZF), .RES_ERR(RES_ERR),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .DBG_STATE(DBG_STATE)
  );

  // Downstream ALU; bitwise ops report junk CF/OF so the sequencer's masking is visible.
  logic [W:0] sum9;
  always_comb begin
    sum9    = '0;
    ALU_OUT = '0;
    ALU_CF  = 1'b0;
    ALU_OF  = 1'b0;
    case (ALU_OPCODE)
      4'h2: begin
        sum9    = {1'b0, ALU_A} + {1'b0, ALU_B};
        ALU_OUT = sum9[W-1:0];
        ALU_CF  = sum9[W];
        ALU_OF  = (ALU_A[W-1] == ALU_B[W-1]) && (ALU_OUT[W-1] != ALU_A[W-1]);
      end
      4'h3: begin
        ALU_OUT = ALU_A - ALU_B;
        ALU_CF  = (ALU_A < ALU_B);
        ALU_OF  = (ALU_A[W-1] != ALU_B[W-1]) && (ALU_OUT[W-1] != ALU_A[W-1]);
      end
      4'h4: begin ALU_OUT = ALU_A & ALU_B; ALU_CF = 1'b1; ALU_OF = 1'b1; end
      4'h5: begin ALU_OUT = ALU_A | ALU_B; ALU_CF = 1'b1; ALU_OF = 1'b1; end
      4'h6: begin ALU_OUT = ALU_A ^ ALU_B; ALU_CF = 1'b1; ALU_OF = 1'b1; end
      4'h7: begin ALU_OUT = ~ALU_A;        ALU_CF = 1'b1; ALU_OF = 1'b1; end
      default: ALU_OUT = '0;
    endcase
    ALU_SF = ALU_OUT[W-1];
    ALU_ZF = (ALU_OUT == '0);
  end

  always @(posedge CLK) if (ALU_EN) en_cnt <= en_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] pack_res(input logic err, input logic cf, input logic of_,
                                           input logic sf, input logic zf, input logic [7:0] d);
    return {err, cf, of_, sf, zf, d};
  endfunction

  task automatic push_instr(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int i;
    IN_OPCODE = op;
    IN_A      = a;
    IN_B      = b;
    IN_VALID  = 1'b1;
    i = 0;
    while (!IN_READY && i < 20) begin
      @(posedge CLK); #1;
      i++;
    end
    check_eq("push_ready", IN_READY, 1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic collect(input string tag);
    logic [12:0] e;
    int i;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h0;
    i = 0;
    while (!RES_VALID && i < 20) begin
      @(posedge CLK); #1;
      i++;
    end
    check_eq({tag, "_valid"}, RES_VALID, 1);
    check_eq({tag, "_data"}, RES_DATA, e[7:0]);
    check_eq({tag, "_flags"}, {RES_ERR, RES_CF, RES_OF, RES_SF, RES_ZF}, e[12:8]);
    RES_READY = 1'b1;
    @(posedge CLK); #1;
    RES_READY = 1'b0;
  endtask

  logic [3:0] v_op [8] = '{4'h3, 4'h6, 4'h7, 4'h5, 4'h4, 4'h2, 4'h3, 4'h3};
  logic [7:0] v_a  [8] = '{8'h05, 8'hF0, 8'h00, 8'h00, 8'hF0, 8'hFF, 8'h00, 8'h80};
  logic [7:0] v_b  [8] = '{8'h05, 8'hFF, 8'h55, 8'h00, 8'h3C, 8'h01, 8'h01, 8'h01};
  // {err,cf,of,sf,zf,data}
  logic [12:0] v_exp [8] = '{13'h01_00, 13'h00_0F, 13'h02_FF, 13'h01_00,
                             13'h00_30, 13'h09_00, 13'h0A_FF, 13'h04_7F};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_before, bad, c, last_c, n_seen;
    logic [12:0] e;

    RST_N = 1'b0; IN_VALID = 1'b0; IN_OPCODE = '0; IN_A = '0; IN_B = '0; RES_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_res_valid", RES_VALID, 0);
    check_eq("rst_in_ready", IN_READY, 1);
    check_eq("rst_alu_en_oe", {ALU_EN, ALU_OE}, 0);
    check_eq("rst_alu_fields", {ALU_OPCODE, ALU_A, ALU_B}, 0);
    check_eq("rst_res_fields", {RES_DATA, RES_CF, RES_OF, RES_SF, RES_ZF, RES_ERR}, 0);
    check_eq("rst_state", DBG_STATE, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // ADD 0x7F+0x01: step through the three edges of latency.
    push_instr(4'h2, 8'h7F, 8'h01);
    check_eq("lat_e0_valid", RES_VALID, 0);
    check_eq("lat_e0_state", DBG_STATE, 0);
    @(posedge CLK); #1;
    check_eq("lat_issue_en", {ALU_EN, ALU_OE}, 2'b10);
    check_eq("lat_issue_fields", {ALU_OPCODE, ALU_A, ALU_B}, {4'h2, 8'h7F, 8'h01});
    @(posedge CLK); #1;
    check_eq("lat_capture_en", {ALU_EN, ALU_OE}, 2'b01);
    check_eq("lat_capture_valid", RES_VALID, 0);
    @(posedge CLK); #1;
    check_eq("lat_e3_valid", RES_VALID, 1);
    check_eq("lat_e3_data", RES_DATA, 8'h80);
    check_eq("lat_e3_flags", {RES_ERR, RES_CF, RES_OF, RES_SF, RES_ZF}, 5'b00110);
    check_eq("lat_e3_alu_oe", ALU_OE, 0);
    @(posedge CLK); #1;
    check_eq("hold_valid", RES_VALID, 1);
    check_eq("hold_data", RES_DATA, 8'h80);
    RES_READY = 1'b1;
    @(posedge CLK); #1;
    RES_READY = 1'b0;
    check_eq("drain_valid", RES_VALID, 0);
    check_eq("drain_alu_op_held", {ALU_OPCODE, ALU_A}, {4'h2, 8'h7F});
    check_eq("drain_state", DBG_STATE, 0);

    // One-at-a-time directed vectors.
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(v_exp[k]);
      push_instr(v_op[k], v_a[k], v_b[k]);
      collect($sformatf("vec%0d", k));
    end

    // Throughput with RES_READY held high.
    exp_q.push_back(pack_res(0, 0, 0, 0, 0, 8'h03));
    exp_q.push_back(pack_res(0, 0, 0, 0, 0, 8'h07));
    exp_q.push_back(pack_res(0, 0, 0, 0, 0, 8'h0B));
    push_instr(4'h2, 8'h01, 8'h02);
    push_instr(4'h2, 8'h03, 8'h04);
    push_instr(4'h2, 8'h05, 8'h06);
    RES_READY = 1'b1;
    last_c = 0;
    n_seen = 0;
    for (c = 1; c <= 15; c++) begin
      @(posedge CLK); #1;
      if (RES_VALID) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h0;
        check_eq("tput_data", RES_DATA, e[7:0]);
        if (n_seen > 0) check_eq("tput_gap", c - last_c, 3);
        last_c = c;
        n_seen++;
      end
    end
    RES_READY = 1'b0;
    check_eq("tput_count", n_seen, 3);

    // Fill: one in the result slot, four in the FIFO, sixth refused.
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(pack_res(0, 0, 0, 0, 0, 8'((i << 4) | i)));
      push_instr(4'h2, 8'(i << 4), 8'(i));
    end
    IN_OPCODE = 4'h2; IN_A = 8'h60; IN_B = 8'h06; IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("full_in_ready", IN_READY, 0);
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    check_eq("full_state", DBG_STATE, 3);
    for (int i = 0; i < 5; i++) collect($sformatf("full%0d", i));

    // Illegal opcode followed by ADD 1+1.
    en_before = en_cnt;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    exp_q.push_back(pack_res(1, 0, 0, 0, 0, 8'h00));
`endif
    exp_q.push_back(pack_res(0, 0, 0, 0, 0, 8'h02));
    push_instr(4'hF, 8'h12, 8'h34);
    push_instr(4'h2, 8'h01, 8'h01);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    collect("trap_err");
`endif
    collect("after_illegal");
    repeat (2) @(posedge CLK);
    #1;
    check_eq("illegal_en_pulses", en_cnt - en_before, 1);
    check_eq("illegal_idle_quiet", {RES_VALID, DBG_STATE}, 0);

    // Reset during CAPTURE with three instructions still queued.
    for (int i = 1; i <= 5; i++) begin
      if (i == 1) exp_q.push_back(pack_res(0, 0, 0, 0, 0, 8'h11));
      push_instr(4'h2, 8'(i << 4), 8'(i));
    end
    collect("pre_rst");
    @(posedge CLK); #1;
    check_eq("pre_rst_state", DBG_STATE, 2);
    check_eq("pre_rst_alu_oe", ALU_OE, 1);
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("async_rst_alu", {ALU_EN, ALU_OE, ALU_OPCODE, ALU_A, ALU_B}, 0);
    check_eq("async_rst_res", {RES_VALID, RES_DATA, RES_CF, RES_OF, RES_SF, RES_ZF, RES_ERR}, 0);
    check_eq("async_rst_in_ready", IN_READY, 1);
    check_eq("async_rst_state", DBG_STATE, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    RES_READY = 1'b1;
    bad = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (RES_VALID || ALU_EN || !IN_READY) bad++;
    end
    RES_READY = 1'b0;
    check_eq("post_rst_quiet", bad, 0);
    check_eq("post_rst_state", DBG_STATE, 0);
    check_eq("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
